// File: rtl/softsw_arbiter_if.sv
// Handshake bundle between the MCU/OSD command sources and the soft-switch arbiter.
// The master side drives commands. The slave side (the arbiter) answers with ready and status.
interface softsw_arbiter_if;
    logic [15:0] mcu_cmd;
    logic        mcu_valid;
    logic        mcu_ready;
    logic [15:0] osd_cmd;
    logic        osd_valid;
    logic        osd_ready;
    logic [15:0] softsw_command;
    logic        busy;
    logic [2:0]  fifo_level;

    modport master (
        output mcu_cmd, mcu_valid, osd_cmd, osd_valid,
        input  mcu_ready, osd_ready, softsw_command, busy, fifo_level
    );

    modport slave (
        input  mcu_cmd, mcu_valid, osd_cmd, osd_valid,
        output mcu_ready, osd_ready, softsw_command, busy, fifo_level
    );
endinterface

// File: rtl/softsw_arbiter.sv
// Round-robin arbiter for MCU/OSD soft-switch commands. It feeds a 4-deep FIFO and an IDLE/DRIVE/GAP sequencer.
// Optional macro SOFTSW_DEDUP_EN: drop a popped command that equals the last one driven.
module softsw_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    softsw_arbiter_if.slave bus
);
    localparam logic [15:0] NOP   = 16'hFF00;
    localparam logic [7:0]  HOLD8 = 8'(HOLD_CYCLES);
    localparam logic [7:0]  GAP8  = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [15:0] fifo [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic        rr_osd;
    logic        full, grant_mcu, grant_osd, push, pop, dup;
    logic [15:0] push_data, head;

`ifdef SOFTSW_DEDUP_EN
    logic [15:0] last_cmd;
    assign dup = (head == last_cmd);
`else
    assign dup = 1'b0;
`endif

    // Ready never looks at a same-cycle pop, so a full FIFO never passes a command through.
    assign full      = (level == 3'd4);
    assign grant_mcu = !reset && bus.mcu_valid && !full && (!bus.osd_valid || !rr_osd);
    assign grant_osd = !reset && bus.osd_valid && !full && (!bus.mcu_valid || rr_osd);
    assign push      = grant_mcu || grant_osd;
    assign push_data = grant_mcu ? bus.mcu_cmd : bus.osd_cmd;
    assign head      = fifo[rd_ptr];
    assign pop       = (state == IDLE) && (level != 3'd0);

    assign bus.mcu_ready  = grant_mcu;
    assign bus.osd_ready  = grant_osd;
    assign bus.fifo_level = level;
    assign bus.busy       = (level != 3'd0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr             <= 2'd0;
            rd_ptr             <= 2'd0;
            level              <= 3'd0;
            rr_osd             <= 1'b0;
            state              <= IDLE;
            cnt                <= 8'd0;
            bus.softsw_command <= NOP;
`ifdef SOFTSW_DEDUP_EN
            last_cmd           <= NOP;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
                rr_osd <= grant_mcu;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            level <= level + {2'b00, push} - {2'b00, pop};

            case (state)
                IDLE: begin
                    // A duplicate is popped and discarded; the sequencer stays idle.
                    if (pop && !dup) begin
                        state              <= DRIVE;
                        cnt                <= HOLD8;
                        bus.softsw_command <= head;
                    end
                end
                DRIVE: begin
                    if (cnt == 8'd1) begin
                        state              <= GAP;
                        cnt                <= GAP8;
                        bus.softsw_command <= NOP;
`ifdef SOFTSW_DEDUP_EN
                        last_cmd           <= bus.softsw_command;
`endif
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'd1) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    cnt                <= 8'd0;
                    bus.softsw_command <= NOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_softsw_arbiter.sv
// Directed bench for softsw_arbiter. It uses a timeline model: each pop owns a drive window and a gap window.
module tb_softsw_arbiter;
    localparam int H = 4;
    localparam int G = 2;
    localparam logic [15:0] NOP = 16'hFF00;
`ifdef SOFTSW_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    softsw_arbiter_if bus();
    softsw_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    logic [15:0] mcu_src[$];
    logic [15:0] osd_src[$];
    // Model state: queued commands, the current drive window and the first cycle the sequencer is free again.
    logic [15:0] mq[$];
    logic [15:0] mlog[$];
    int cyc = 0, ds = 1, de = 0, idle_at = 0;
    logic [15:0] dcmd = NOP, mlast = NOP;
    bit fav_osd = 1'b0, acc_m = 1'b0, acc_o = 1'b0;
    int max_lvl = 0, blocked = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_mr();
        return !reset && bus.mcu_valid && (mq.size() != 4) && (!bus.osd_valid || !fav_osd);
    endfunction

    function automatic logic exp_or();
        return !reset && bus.osd_valid && (mq.size() != 4) && (!bus.mcu_valid || fav_osd);
    endfunction

    always @(posedge clk) begin
        int c;
        logic gm, go;
        logic [15:0] h;
        c = cyc;
        cyc = c + 1;
        gm = exp_mr();
        go = exp_or();
        if (reset) begin
            mq.delete();
            fav_osd = 1'b0; ds = 1; de = 0; idle_at = 0; mlast = NOP; dcmd = NOP;
        end else begin
            if (c >= idle_at && mq.size() != 0) begin
                h = mq.pop_front();
                if (!(DEDUP && h == mlast)) begin
                    ds = c + 1; de = c + H; idle_at = c + H + G + 1;
                    dcmd = h; mlast = h;
                    mlog.push_back(h);
                end
            end
            if (gm) begin mq.push_back(bus.mcu_cmd); fav_osd = 1'b1; end
            if (go) begin mq.push_back(bus.osd_cmd); fav_osd = 1'b0; end
        end
        acc_m = gm;
        acc_o = go;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mcu_ready", 16'(bus.mcu_ready), 16'(exp_mr()));
            chk("osd_ready", 16'(bus.osd_ready), 16'(exp_or()));
            chk("softsw_command", bus.softsw_command, (cyc >= ds && cyc <= de) ? dcmd : NOP);
            chk("fifo_level", 16'(bus.fifo_level), 16'(mq.size()));
            chk("busy", 16'(bus.busy), 16'(mq.size() != 0 || cyc < idle_at));
        end
    end

    function automatic void apply_src();
        bus.mcu_valid = (mcu_src.size() != 0);
        bus.mcu_cmd   = (mcu_src.size() != 0) ? mcu_src[0] : 16'h0000;
        bus.osd_valid = (osd_src.size() != 0);
        bus.osd_cmd   = (osd_src.size() != 0) ? osd_src[0] : 16'h0000;
    endfunction

    task automatic tick();
        logic [15:0] d;
        @(posedge clk);
        #1;
        if (acc_m) d = mcu_src.pop_front();
        if (acc_o) d = osd_src.pop_front();
        apply_src();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    function automatic bit model_idle();
        return mcu_src.size() == 0 && osd_src.size() == 0 && mq.size() == 0 && cyc >= idle_at;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        max_lvl = 0;
        blocked = 0;
        do begin
            tick();
            @(negedge clk);
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
            if (bus.fifo_level == 3'd4 && bus.mcu_valid && !bus.mcu_ready) blocked++;
            n++;
        end while (!model_idle() && n < 300);
        if (n >= 300) chk(name, 16'd1, 16'd0);
    endtask

    initial begin
        int t0;
        apply_src();
        tick();
        tick();
        chk_en = 1'b1;
        // Reset values, with a requester asserting valid during reset.
        bus.mcu_valid = 1'b1;
        bus.mcu_cmd = 16'h1234;
        @(negedge clk);
        chk("rst_cmd", bus.softsw_command, NOP);
        chk("rst_level", 16'(bus.fifo_level), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_mcu_ready", 16'(bus.mcu_ready), 16'd0);
        chk("rst_osd_ready", 16'(bus.osd_ready), 16'd0);
        do_reset(1);

        // Single command latency and window lengths.
        tick(); tick();
        mlog.delete();
        mcu_src.push_back(16'h0701);
        apply_src();
        t0 = cyc;
        @(negedge clk);
        chk("s1_ready", 16'(bus.mcu_ready), 16'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            @(negedge clk);
            if (k >= 2 && k <= 5) chk("s1_drive", bus.softsw_command, 16'h0701);
            else chk("s1_nop", bus.softsw_command, NOP);
            chk("s1_busy", 16'(bus.busy), 16'(k <= 7));
        end
        chk("s1_elapsed", 16'(cyc - t0), 16'd8);
        chk("s1_log_n", 16'(mlog.size()), 16'd1);

        // Contention straight after reset: MCU first, then OSD.
        do_reset(2);
        mlog.delete();
        mcu_src.push_back(16'h0002);
        osd_src.push_back(16'h0501);
        apply_src();
        @(negedge clk);
        chk("s2_mcu_first", 16'(bus.mcu_ready), 16'd1);
        chk("s2_osd_wait", 16'(bus.osd_ready), 16'd0);
        tick();
        @(negedge clk);
        chk("s2_osd_next", 16'(bus.osd_ready), 16'd1);
        wait_idle("s2_timeout");
        chk("s2_log_n", 16'(mlog.size()), 16'd2);
        chk("s2_order0", (mlog.size() > 0) ? mlog[0] : 16'hDEAD, 16'h0002);
        chk("s2_order1", (mlog.size() > 1) ? mlog[1] : 16'hDEAD, 16'h0501);

        // Backpressure: six back-to-back MCU commands.
        mlog.delete();
        for (int i = 0; i < 6; i++) mcu_src.push_back(16'h1001 + 16'(i));
        apply_src();
        wait_idle("s3_timeout");
        chk("s3_max_level", 16'(max_lvl), 16'd4);
        chk("s3_blocked_full", 16'(blocked != 0), 16'd1);
        chk("s3_log_n", 16'(mlog.size()), 16'd6);
        for (int i = 0; i < 6; i++)
            chk("s3_order", (i < mlog.size()) ? mlog[i] : 16'hDEAD, 16'h1001 + 16'(i));

        // Repeated command.
        mlog.delete();
        mcu_src.push_back(16'h0E01);
        mcu_src.push_back(16'h0E01);
        apply_src();
        wait_idle("s4_timeout");
        chk("s4_log_n", 16'(mlog.size()), DEDUP ? 16'd1 : 16'd2);
        chk("s4_level", 16'(bus.fifo_level), 16'd0);

        // Reset in the second DRIVE cycle with two commands still queued.
        mlog.delete();
        mcu_src.push_back(16'hA0A1);
        mcu_src.push_back(16'hA0A2);
        mcu_src.push_back(16'hA0A3);
        apply_src();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (dcmd == 16'hA0A1 && cyc == ds + 1) break;
        end
        chk("s5_in_drive", bus.softsw_command, 16'hA0A1);
        reset = 1'b1;
        @(negedge clk);
        chk("s5_queued", 16'(bus.fifo_level), 16'd2);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("s5_cmd_nop", bus.softsw_command, NOP);
        chk("s5_level0", 16'(bus.fifo_level), 16'd0);
        chk("s5_busy0", 16'(bus.busy), 16'd0);
        repeat (20) tick();
        chk("s5_log_n", 16'(mlog.size()), 16'd1);
        chk("s5_log0", (mlog.size() > 0) ? mlog[0] : 16'hDEAD, 16'hA0A1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/softsw_arbiter.md
SOFTSW_ARBITER -- requirements
Module: softsw_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, which sets the number of cycles each command word is driven (legal range 1..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, which sets the number of cycles the NOP word is driven between commands (legal range 1..255).
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mcu_cmd  input  16  command from the MCU/SPI path: [15:8] switch address, [7:0] value.
- mcu_valid  input  1  mcu_cmd is valid.
- mcu_ready  output  1  the MCU command is accepted this cycle.
- osd_cmd  input  16  command from the OSD/hotkey path, same format as mcu_cmd.
- osd_valid  input  1  osd_cmd is valid.
- osd_ready  output  1  the OSD command is accepted this cycle.
- softsw_command  output  16  registered word driven to the soft-switch decoder.
- busy  output  1  high when the FIFO is non-empty or the sequencer is not IDLE.
- fifo_level  output  3  FIFO occupancy, 0..4.

Function
REQ-004 A command SHALL transfer only in a cycle where valid and ready are both high for that requester; the requester SHALL hold cmd stable while valid is high and ready is low.
REQ-005 Readiness SHALL follow these rules:
- ready SHALL be combinational from valid, the FIFO-full flag and the round-robin pointer.
- ready SHALL never depend on a same-cycle pop, so there is no pass-through when the FIFO is full.
REQ-006 At most one requester SHALL be granted per cycle.
- If only one requester is valid and the FIFO is not full, that requester SHALL be granted.
- If both are valid, the requester not granted last SHALL win (round-robin).
- After reset the pointer SHALL favour MCU.
REQ-007 Accepted commands SHALL enter a 4-entry FIFO in acceptance order.
- A push and a pop in the same cycle SHALL leave the level unchanged.
- The FIFO SHALL never overflow or underflow.
REQ-008 The sequencer FSM SHALL have three states: IDLE, DRIVE and GAP.
REQ-009 IDLE: if the FIFO is non-empty, the sequencer SHALL pop the head entry into the command register and move to DRIVE; otherwise it SHALL stay in IDLE.
REQ-010 DRIVE: softsw_command SHALL equal the popped command for exactly HOLD_CYCLES cycles, after which the FSM SHALL move to GAP.
REQ-011 GAP: softsw_command SHALL equal NOP = 16'hFF00 (address 255, unused) for exactly GAP_CYCLES cycles, after which the FSM SHALL move to IDLE.
REQ-012 The FSM SHALL spend at least 1 cycle in IDLE between commands. Each command's sequence is therefore 1 + HOLD_CYCLES + GAP_CYCLES cycles.
REQ-013 Latency SHALL be as follows: a command accepted in cycle t while the FIFO is empty and the FSM is in IDLE is popped in cycle t+1 and appears on softsw_command from cycle t+2.
REQ-014 softsw_command SHALL be NOP at all times outside DRIVE, so that consecutive identical commands each produce a change on the decoder's change-detect input.
REQ-015 HOLD_CYCLES and GAP_CYCLES SHALL be counted with an 8-bit down-counter loaded on each state entry; no wrap-around is permitted.
REQ-016 busy and fifo_level SHALL be registered or derived from registered state only.

Reset
REQ-017 While reset is high, the block SHALL hold these values:
- FIFO empty, fifo_level = 0.
- FSM in IDLE, counters at 0.
- round-robin pointer favouring MCU.
- softsw_command = 16'hFF00.
- busy = 0, mcu_ready = 0, osd_ready = 0.
REQ-018 A reset asserted mid-operation SHALL discard the FIFO contents and any command in DRIVE; softsw_command SHALL be NOP in the cycle after reset is sampled.

Configuration
REQ-019 When macro SOFTSW_DEDUP_EN is defined, the sequencer SHALL handle duplicates as follows:
- It SHALL compare each popped command against the last command that completed DRIVE.
- If they are equal, it SHALL drop the command: the FSM stays in IDLE and the command is never driven.
- The last-command register SHALL reset to 16'hFF00.
REQ-020 When SOFTSW_DEDUP_EN is not defined, every accepted command SHALL be driven, including repeats.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single command: with HOLD_CYCLES=4 and GAP_CYCLES=2, MCU sends 16'h0701 in cycle 10 -> mcu_ready=1 in cycle 10, softsw_command=16'h0701 in cycles 12..15, 16'hFF00 in cycles 16..17, busy=0 from cycle 18.
- Contention: MCU 16'h0002 and OSD 16'h0501 are both valid in the same cycle after reset -> MCU is granted first and OSD on the next cycle; outputs appear in order 0002 then 0501, each separated by NOP.
- Backpressure: 6 back-to-back MCU commands with the sequencer busy -> fifo_level reaches 4, mcu_ready stays low while full, and all 6 commands are driven in order with none lost.
- Repeat: 16'h0E01 sent twice -> without SOFTSW_DEDUP_EN it is driven twice with NOP between; with SOFTSW_DEDUP_EN it is driven once and fifo_level returns to 0.
- Reset mid-DRIVE: reset asserted in the second DRIVE cycle with 2 commands queued -> softsw_command=16'hFF00, fifo_level=0 and busy=0 the next cycle, and the queued commands are never driven.
